// File: rtl/ram_arbiter_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : ram_arbiter_ctrl
// Purpose : Two-requester round-robin write arbiter plus a pipelined read path
//           for an external RAM with a one-cycle registered read port.
//           The optional macro RAM_COLLISION_STALL_EN stalls a read that
//           targets the address being written in the same cycle.
// Revision: 1.0  initial release
// ============================================================================
module ram_arbiter_ctrl #(
    parameter int SIZE  = 8,
    parameter int DEPTH = 8,
    localparam int AW   = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic            clk,
    input  logic            rst_n,

    input  logic            req0_valid,
    input  logic [AW-1:0]   req0_addr,
    input  logic [SIZE-1:0] req0_data,
    output logic            req0_ready,

    input  logic            req1_valid,
    input  logic [AW-1:0]   req1_addr,
    input  logic [SIZE-1:0] req1_data,
    output logic            req1_ready,

    input  logic            rd_valid,
    input  logic [AW-1:0]   rd_addr,
    output logic            rd_ready,
    output logic [SIZE-1:0] rd_data,
    output logic            rd_data_valid,

    output logic [AW-1:0]   ram_waddr,
    output logic [SIZE-1:0] ram_write_data,
    output logic            ram_write_en,
    output logic [AW-1:0]   ram_raddr,
    input  logic [SIZE-1:0] ram_read_data,

    output logic            prio
);

    logic            grant_any;
    logic            grant_sel;
    logic            wr_accept;
    logic [AW-1:0]   grant_addr;
    logic [SIZE-1:0] grant_data;
    logic            rd_collision;
    logic            rd_accept;
    logic [1:0]      rd_pipe;

    // Contention is resolved by prio; a lone requester always wins.
    always_comb begin
        grant_any = req0_valid | req1_valid;
        grant_sel = (req0_valid && req1_valid) ? prio : req1_valid;
    end

    assign req0_ready = rst_n & grant_any & ~grant_sel;
    assign req1_ready = rst_n & grant_any &  grant_sel;
    assign wr_accept  = req0_ready | req1_ready;
    assign grant_addr = grant_sel ? req1_addr : req0_addr;
    assign grant_data = grant_sel ? req1_data : req0_data;

`ifdef RAM_COLLISION_STALL_EN
    // Holding the read one cycle lets the write land first, so it sees new data.
    assign rd_collision = rd_valid & wr_accept & (rd_addr == grant_addr);
`else
    assign rd_collision = 1'b0;
`endif

    assign rd_ready  = rst_n & ~rd_collision;
    assign rd_accept = rd_valid & rd_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ram_write_en   <= 1'b0;
            ram_waddr      <= '0;
            ram_write_data <= '0;
            prio           <= 1'b0;
        end else begin
            ram_write_en <= wr_accept;
            if (wr_accept) begin
                ram_waddr      <= grant_addr;
                ram_write_data <= grant_data;
                prio           <= ~grant_sel;
            end
        end
    end

    // rd_pipe[1] lines up with the RAM's registered read data two cycles on.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ram_raddr <= '0;
            rd_pipe   <= 2'b00;
        end else begin
            rd_pipe <= {rd_pipe[0], rd_accept};
            if (rd_accept) begin
                ram_raddr <= rd_addr;
            end
        end
    end

    assign rd_data_valid = rd_pipe[1];
    assign rd_data       = ram_read_data;

endmodule
`default_nettype wire

// File: tb/tb_ram_arbiter_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : tb_ram_arbiter_ctrl
// Purpose : Directed scoreboard bench for ram_arbiter_ctrl with a RAM model.
// Revision: 1.0  initial release
// ============================================================================
module tb_ram_arbiter_ctrl;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       req0_valid, req1_valid, rd_valid;
    logic [2:0] req0_addr, req1_addr, rd_addr;
    logic [7:0] req0_data, req1_data;
    logic       req0_ready, req1_ready, rd_ready;
    logic [7:0] rd_data;
    logic       rd_data_valid;
    logic [2:0] ram_waddr, ram_raddr;
    logic [7:0] ram_write_data;
    logic       ram_write_en;
    logic [7:0] ram_read_data;
    logic       prio;

    ram_arbiter_ctrl #(.SIZE(8), .DEPTH(8)) dut (
        .clk(clk), .rst_n(rst_n),
        .req0_valid(req0_valid), .req0_addr(req0_addr), .req0_data(req0_data), .req0_ready(req0_ready),
        .req1_valid(req1_valid), .req1_addr(req1_addr), .req1_data(req1_data), .req1_ready(req1_ready),
        .rd_valid(rd_valid), .rd_addr(rd_addr), .rd_ready(rd_ready),
        .rd_data(rd_data), .rd_data_valid(rd_data_valid),
        .ram_waddr(ram_waddr), .ram_write_data(ram_write_data), .ram_write_en(ram_write_en),
        .ram_raddr(ram_raddr), .ram_read_data(ram_read_data),
        .prio(prio)
    );

    always #5 clk = ~clk;

    // External RAM: synchronous write, registered read.
    logic [7:0] mem [8];
    always @(posedge clk) begin
        if (ram_write_en) mem[ram_waddr] <= ram_write_data;
        ram_read_data <= mem[ram_raddr];
    end

    typedef struct {int due; logic [2:0] addr; logic [7:0] data;} wr_t;
    typedef struct {int due; logic [7:0] data;} rd_t;

    wr_t        wq[$];
    rd_t        rq[$];
    logic [7:0] shadow [8];
    logic       m_prio;
    int         edge_n;
    int         compared;
    int         mismatched;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_reset_state();
        chk("rst.ram_write_en", ram_write_en, 0);
        chk("rst.rd_data_valid", rd_data_valid, 0);
        chk("rst.ram_waddr", ram_waddr, 0);
        chk("rst.ram_write_data", ram_write_data, 0);
        chk("rst.ram_raddr", ram_raddr, 0);
        chk("rst.prio", prio, 0);
        chk("rst.req0_ready", req0_ready, 0);
        chk("rst.req1_ready", req1_ready, 0);
        chk("rst.rd_ready", rd_ready, 0);
    endtask

    task automatic check_outputs(input int obs_edge);
        wr_t w;
        rd_t r;
        if (wq.size() > 0 && wq[0].due == obs_edge) begin
            w = wq.pop_front();
            chk("ram_write_en", ram_write_en, 1);
            chk("ram_waddr", ram_waddr, w.addr);
            chk("ram_write_data", ram_write_data, w.data);
        end else begin
            chk("ram_write_en_idle", ram_write_en, 0);
        end
        if (rq.size() > 0 && rq[0].due == obs_edge) begin
            r = rq.pop_front();
            chk("rd_data_valid", rd_data_valid, 1);
            chk("rd_data", rd_data, r.data);
        end else begin
            chk("rd_data_valid_idle", rd_data_valid, 0);
        end
        chk("prio", prio, m_prio);
    endtask

    // One clock: check handshakes for the current inputs, predict, cross the edge, check outputs.
    task automatic cycle();
        logic       g_any, g_sel, e_rr;
        logic [2:0] g_addr;
        logic [7:0] g_data;
        wr_t        w;
        rd_t        r;
        #1;
        g_any  = rst_n && (req0_valid || req1_valid);
        g_sel  = (req0_valid && req1_valid) ? m_prio : req1_valid;
        g_addr = g_sel ? req1_addr : req0_addr;
        g_data = g_sel ? req1_data : req0_data;
        e_rr   = rst_n;
`ifdef RAM_COLLISION_STALL_EN
        if (rd_valid && g_any && rd_addr == g_addr) e_rr = 1'b0;
`endif
        chk("req0_ready", req0_ready, g_any && !g_sel);
        chk("req1_ready", req1_ready, g_any && g_sel);
        chk("rd_ready", rd_ready, e_rr);
        if (rd_valid && e_rr) begin
            r.due  = edge_n + 1;
            r.data = shadow[rd_addr];
            rq.push_back(r);
        end
        if (g_any) begin
            w.due  = edge_n;
            w.addr = g_addr;
            w.data = g_data;
            wq.push_back(w);
            shadow[g_addr] = g_data;
            m_prio = !g_sel;
        end
        @(negedge clk);
        check_outputs(edge_n);
        edge_n++;
    endtask

    task automatic idle_inputs();
        req0_valid = 0; req1_valid = 0; rd_valid = 0;
        req0_addr = 0; req1_addr = 0; rd_addr = 0;
        req0_data = 0; req1_data = 0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        compared = 0; mismatched = 0; edge_n = 0; m_prio = 0;
        for (int i = 0; i < 8; i++) begin
            mem[i] = 8'h00;
            shadow[i] = 8'h00;
        end
        idle_inputs();
        rst_n = 0;
        // Requests held active during reset must not be granted.
        req0_valid = 1; req1_valid = 1; rd_valid = 1;
        @(negedge clk);
        @(negedge clk);
        chk_reset_state();
        idle_inputs();
        rst_n = 1;

        // Both requesters contend for four cycles: grants alternate 0,1,0,1.
        req0_valid = 1; req0_addr = 3'd1; req0_data = 8'hA1;
        req1_valid = 1; req1_addr = 3'd2; req1_data = 8'hB2;
        repeat (4) cycle();
        idle_inputs();
        repeat (2) cycle();

        // Lone requester 1 wins; prio then points at requester 0.
        req1_valid = 1; req1_addr = 3'd5; req1_data = 8'h5C;
        cycle();
        idle_inputs();
        cycle();

        // Write then read back two cycles later.
        req0_valid = 1; req0_addr = 3'd3; req0_data = 8'h3C;
        cycle();
        idle_inputs();
        cycle();
        rd_valid = 1; rd_addr = 3'd3;
        cycle();
        idle_inputs();
        repeat (2) cycle();

        // Back-to-back reads alongside writes to an unrelated address.
        req0_valid = 1; req0_addr = 3'd6; req0_data = 8'h66;
        rd_valid = 1; rd_addr = 3'd1;
        cycle();
        req0_data = 8'h67; rd_addr = 3'd2;
        cycle();
        req0_valid = 0; rd_addr = 3'd5;
        cycle();
        rd_addr = 3'd6;
        cycle();
        idle_inputs();
        repeat (3) cycle();

`ifdef RAM_COLLISION_STALL_EN
        // Read and write hit address 4 together: read waits one cycle and sees 0x77.
        req0_valid = 1; req0_addr = 3'd4; req0_data = 8'h77;
        rd_valid = 1; rd_addr = 3'd4;
        cycle();
        req0_valid = 0;
        cycle();
        idle_inputs();
        repeat (3) cycle();
`else
        // Without collision protection a read is ready regardless of a concurrent write.
        req1_valid = 1; req1_addr = 3'd4; req1_data = 8'h44;
        rd_valid = 1; rd_addr = 3'd0;
        cycle();
        idle_inputs();
        repeat (3) cycle();
`endif

        // Reads in flight are dropped by a mid-cycle reset.
        rd_valid = 1; rd_addr = 3'd0;
        cycle();
        rd_addr = 3'd1;
        cycle();
        rd_addr = 3'd2;
        #2;
        rst_n = 0;
        #1;
        chk_reset_state();
        rq.delete();
        wq.delete();
        m_prio = 0;
        @(negedge clk);
        @(negedge clk);
        chk_reset_state();
        idle_inputs();
        rst_n = 1;
        repeat (4) cycle();

        // Normal operation resumes immediately after release.
        req1_valid = 1; req1_addr = 3'd7; req1_data = 8'hE7;
        rd_valid = 1; rd_addr = 3'd3;
        cycle();
        idle_inputs();
        rd_valid = 1; rd_addr = 3'd7;
        cycle();
        cycle();
        idle_inputs();
        repeat (3) cycle();

        chk("scoreboard_rd_empty", rq.size(), 0);
        chk("scoreboard_wr_empty", wq.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
`default_nettype wire
